// File: rtl/store_trace_monitor_if.sv
// Store bus from the processor plus the valid/ready drain port of the trace FIFO.
// The monitor takes the slave side; the producer/consumer environment takes the master side.
interface store_trace_monitor_if;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [31:0] out_data;

    modport master (
        output MemWrite, DataAdr, WriteData, out_ready,
        input  out_valid, out_addr, out_data
    );

    modport slave (
        input  MemWrite, DataAdr, WriteData, out_ready,
        output out_valid, out_addr, out_data
    );
endinterface

// File: rtl/store_trace_monitor.sv
// Captures stores that land in a scratch window into a small FIFO and keeps a
// sticky pass/fail/timeout verdict driven by a store to PASS_ADDR.
module store_trace_monitor #(
    parameter int unsigned DEPTH     = 8,
    parameter logic [31:0] WIN_BASE  = 32'd96,
    parameter logic [31:0] WIN_SIZE  = 32'd4,
    parameter logic [31:0] PASS_ADDR = 32'd100,
    parameter logic [31:0] PASS_DATA = 32'd25,
    parameter int unsigned TIMEOUT   = 1000
) (
    input  logic                     clk,
    input  logic                     reset,
    store_trace_monitor_if.slave     bus,
    output logic [$clog2(DEPTH):0]   fill,
    output logic [15:0]              drop_cnt,
    output logic                     pass,
    output logic                     fail
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int FILL_W = PTR_W + 1;
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);
    localparam logic [32:0] WIN_LO = {1'b0, WIN_BASE};
    localparam logic [32:0] WIN_HI = {1'b0, WIN_BASE} + {1'b0, WIN_SIZE};

    typedef enum logic [1:0] {ST_RUN, ST_PASS, ST_FAIL} stateT;

    stateT             state;
    stateT             nextState;
    logic [63:0]       mem [DEPTH];
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W-1:0]  rdNext;
    logic [31:0]       toCnt;
    logic [31:0]       headAddr;
    logic [31:0]       headData;
    logic [32:0]       adrWide;
    logic              inWindow;
    logic              pushReq;
    logic              doPush;
    logic              doPop;
    logic              full;
    logic              empty;

    // 33-bit compare so a window ending at 2^32 does not wrap to zero.
    assign adrWide  = {1'b0, bus.DataAdr};
    assign inWindow = (adrWide >= WIN_LO) && (adrWide < WIN_HI);

    assign full    = (fill == FILL_W'(DEPTH));
    assign empty   = (fill == '0);
    assign pushReq = (state == ST_RUN) && bus.MemWrite && inWindow;
    assign doPop   = !empty && bus.out_ready;
    assign doPush  = pushReq && (!full || doPop);
    assign rdNext  = doPop ? rdPtr + PTR_W'(1) : rdPtr;

    assign bus.out_valid = !empty;
    assign bus.out_addr  = headAddr;
    assign bus.out_data  = headData;
    assign pass = (state == ST_PASS);
    assign fail = (state == ST_FAIL);

    // A verdict store in the timeout cycle takes priority over the timeout.
    always_comb begin
        nextState = state;
        if (state == ST_RUN) begin
            if (bus.MemWrite && bus.DataAdr == PASS_ADDR) begin
                nextState = (bus.WriteData == PASS_DATA) ? ST_PASS : ST_FAIL;
            end else if (bus.MemWrite && !inWindow) begin
                nextState = ST_FAIL;
            end else if (TIMEOUT != 0 && toCnt == TIMEOUT_LAST) begin
                nextState = ST_FAIL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= nextState;
        end
    end

    // NOTE: the storage array has no reset; occupancy is tracked by the pointers and fill.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= {bus.DataAdr, bus.WriteData};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            toCnt    <= '0;
            wrPtr    <= '0;
            rdPtr    <= '0;
            fill     <= '0;
            drop_cnt <= '0;
            headAddr <= '0;
            headData <= '0;
        end else begin
            if (state == ST_RUN) begin
                toCnt <= toCnt + 32'd1;
            end
            if (doPush) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            rdPtr <= rdNext;
            if (doPush && !doPop) begin
                fill <= fill + FILL_W'(1);
            end else if (doPop && !doPush) begin
                fill <= fill - FILL_W'(1);
            end
            if (pushReq && !doPush && drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
            // The head register holds its value once the FIFO drains empty.
            if (doPush && fill == (doPop ? FILL_W'(1) : FILL_W'(0))) begin
                headAddr <= bus.DataAdr;
                headData <= bus.WriteData;
            end else if (doPop && fill != FILL_W'(1)) begin
                {headAddr, headData} <= mem[rdNext];
            end
        end
    end
endmodule

// File: tb/tb_store_trace_monitor.sv
// Directed bench: stimulus queues expected FIFO entries, a negedge monitor pops
// and compares them on each handshake; status outputs are checked inline.
module tb_store_trace_monitor;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        reset2 = 1'b1;
    logic [3:0]  fill, fill2;
    logic [15:0] drop_cnt, drop2;
    logic        pass, fail, pass2, fail2;

    int checks = 0;
    int failures = 0;
    logic [63:0] expQ [$];

    store_trace_monitor_if bus ();
    store_trace_monitor_if bus2 ();

    store_trace_monitor dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .fill     (fill),
        .drop_cnt (drop_cnt),
        .pass     (pass),
        .fail     (fail)
    );

    store_trace_monitor #(.TIMEOUT(20)) dutTo (
        .clk      (clk),
        .reset    (reset2),
        .bus      (bus2),
        .fill     (fill2),
        .drop_cnt (drop2),
        .pass     (pass2),
        .fail     (fail2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        bus.MemWrite  = 1'b1;
        bus.DataAdr   = a;
        bus.WriteData = d;
        tick();
        bus.MemWrite  = 1'b0;
    endtask

    // Scoreboard monitor: a handshake visible at the negedge completes at the next posedge.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pop: got %0h/%0h expected none", bus.out_addr, bus.out_data);
                end else begin
                    e = expQ.pop_front();
                    check("head_addr", 64'(bus.out_addr), 64'(e[63:32]));
                    check("head_data", 64'(bus.out_data), 64'(e[31:0]));
                end
            end
        end
    end

    initial begin
        bus.MemWrite   = 1'b1;
        bus.DataAdr    = 32'd96;
        bus.WriteData  = 32'd7;
        bus.out_ready  = 1'b0;
        bus2.MemWrite  = 1'b0;
        bus2.DataAdr   = 32'd0;
        bus2.WriteData = 32'd0;
        bus2.out_ready = 1'b0;

        // Reset held with a store present; it must be ignored.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_fill", 64'(fill), 64'd0);
            check("rst_valid", 64'(bus.out_valid), 64'd0);
            check("rst_verdict", 64'({pass, fail}), 64'd0);
            check("rst_drop", 64'(drop_cnt), 64'd0);
        end
        check("rst_addr", 64'(bus.out_addr), 64'd0);
        reset = 1'b0;
        bus.MemWrite = 1'b0;
        tick();
        check("post_rst_fill", 64'(fill), 64'd0);
        check("post_rst_valid", 64'(bus.out_valid), 64'd0);
        check("post_rst_verdict", 64'({pass, fail}), 64'd0);

        // Two captured stores then a passing verdict; drain afterwards.
        doReset();
        store(32'd96, 32'd5);
        expQ.push_back({32'd96, 32'd5});
        check("push_visible", 64'(bus.out_valid), 64'd1);
        store(32'd96, 32'd10);
        expQ.push_back({32'd96, 32'd10});
        store(32'd100, 32'd25);
        check("pass_fill", 64'(fill), 64'd2);
        check("pass_flag", 64'(pass), 64'd1);
        check("pass_nofail", 64'(fail), 64'd0);
        bus.out_ready = 1'b1;
        tick();
        tick();
        bus.out_ready = 1'b0;
        check("drained_valid", 64'(bus.out_valid), 64'd0);
        check("drained_fill", 64'(fill), 64'd0);
        check("hold_last_data", 64'(bus.out_data), 64'd10);

        // Overfill: 10 stores into 8 entries, then push+pop on full.
        doReset();
        for (int i = 1; i <= 10; i++) begin
            store(32'd96, 32'(i));
            if (i <= 8) expQ.push_back({32'd96, 32'(i)});
        end
        check("full_fill", 64'(fill), 64'd8);
        check("full_drop", 64'(drop_cnt), 64'd2);
        check("full_head", 64'(bus.out_data), 64'd1);
        bus.out_ready = 1'b1;
        expQ.push_back({32'd96, 32'd11});
        store(32'd96, 32'd11);
        bus.out_ready = 1'b0;
        check("full_pushpop_fill", 64'(fill), 64'd8);
        check("full_pushpop_head", 64'(bus.out_data), 64'd2);
        check("full_pushpop_drop", 64'(drop_cnt), 64'd2);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        bus.out_ready = 1'b0;
        check("full_drained", 64'(fill), 64'd0);

        // Wrong data to PASS_ADDR fails; later stores change nothing.
        doReset();
        store(32'd100, 32'd24);
        check("bad_data_verdict", 64'({pass, fail}), 64'b01);
        store(32'd100, 32'd25);
        check("absorb_verdict", 64'({pass, fail}), 64'b01);
        store(32'd96, 32'd3);
        check("no_capture_fill", 64'(fill), 64'd0);
        check("no_capture_drop", 64'(drop_cnt), 64'd0);

        // Stray address fails immediately.
        doReset();
        store(32'd200, 32'd1);
        check("stray_verdict", 64'({pass, fail}), 64'b01);

        // Mid-operation reset clears FIFO and verdict; capture resumes.
        doReset();
        for (int i = 1; i <= 5; i++) store(32'd96, 32'(i));
        store(32'd100, 32'd25);
        check("pre_rst_fill", 64'(fill), 64'd5);
        check("pre_rst_pass", 64'(pass), 64'd1);
        doReset();
        check("mid_rst_fill", 64'(fill), 64'd0);
        check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_verdict", 64'({pass, fail}), 64'd0);
        expQ.push_back({32'd97, 32'd42});
        store(32'd97, 32'd42);
        check("resume_fill", 64'(fill), 64'd1);
        check("resume_head", 64'(bus.out_data), 64'd42);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // Idle timeout with TIMEOUT=20: fail lands on the 20th edge after release.
        reset2 = 1'b0;
        for (int i = 0; i < 19; i++) tick();
        check("timeout_early", 64'(fail2), 64'd0);
        tick();
        check("timeout_fail", 64'(fail2), 64'd1);
        check("timeout_nopass", 64'(pass2), 64'd0);

        check("scoreboard_empty", 64'(expQ.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
